// File: rtl/computer_pkg.sv
// Shared widths, opcode constants and stage encodings for the computer.
package computer_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned NREG   = 8;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_ADDI = 4'h6;
  localparam logic [3:0] OP_LDI  = 4'h7;
  localparam logic [3:0] OP_LD   = 4'h8;
  localparam logic [3:0] OP_ST   = 4'h9;
  localparam logic [3:0] OP_BEQ  = 4'hA;
  localparam logic [3:0] OP_JMP  = 4'hB;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEMORY    = 3'd3,
    WRITEBACK = 3'd4,
    HALT      = 3'd5
  } stage_t;

  // True for every opcode that commits a result to rd in WRITEBACK.
  function automatic logic writes_rd(input logic [3:0] op);
    return (op >= OP_ADD && op <= OP_LD);
  endfunction

endpackage

// File: rtl/computer_mcpu.sv
// Multi-cycle CPU core and its 8 x 16 register file.
module RegisterFile
  import computer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        ra1,
  input  logic [2:0]        ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              we,
  input  logic [2:0]        wa,
  input  logic [DATA_W-1:0] wd
);

  logic [NREG*DATA_W-1:0] cpu_registers = '0;

  // Two combinational read ports; r0 always reads zero.
  always_comb begin
    rd1 = (ra1 == '0) ? '0 : cpu_registers[{ra1, 4'b0000} +: DATA_W];
    rd2 = (ra2 == '0) ? '0 : cpu_registers[{ra2, 4'b0000} +: DATA_W];
  end

  // Write port; writes to r0 are dropped.
  always_ff @(posedge clk) begin
    if (rst) cpu_registers <= '0;
    else if (we && wa != '0) cpu_registers[{wa, 4'b0000} +: DATA_W] <= wd;
  end

endmodule

module MCPU
  import computer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] rom_data,
  input  logic [DATA_W-1:0] cur_memory_data,
  output logic [ADDR_W-1:0] pc_addr,
  output logic [DATA_W-1:0] instruction,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_write,
  output logic              mem_write_enabled
);

  stage_t stage = FETCH;
  stage_t stage_next;

  logic [ADDR_W-1:0] pc        = '0;
  logic [DATA_W-1:0] ir        = '0;
  logic [DATA_W-1:0] a         = '0;
  logic [DATA_W-1:0] b         = '0;
  logic [DATA_W-1:0] alu_out   = '0;
  logic [DATA_W-1:0] mdr       = '0;
  logic [ADDR_W-1:0] maddr     = '0;
  logic [DATA_W-1:0] mwdata    = '0;
  logic              mwe       = 1'b0;

  logic [3:0]        op;
  logic [2:0]        rd, rs, rt;
  logic [DATA_W-1:0] imm6_sext;
  logic [DATA_W-1:0] alu_res;
  logic [2:0]        ra2;
  logic [DATA_W-1:0] rd1, rd2;
  logic              rf_we;
  logic [DATA_W-1:0] rf_wd;

  assign op = ir[15:12];
  assign rd = ir[11:9];
  assign rs = ir[8:6];
  assign rt = ir[5:3];
  assign imm6_sext = {{10{ir[5]}}, ir[5:0]};

  assign pc_addr           = pc;
  assign instruction       = ir;
  assign mem_addr          = maddr;
  assign mem_data_write    = mwdata;
  assign mem_write_enabled = mwe;

  // Stage register.
  always_ff @(posedge clk) begin
    if (rst) stage <= FETCH;
    else     stage <= stage_next;
  end

  // Stage sequencing; HALT is entered from DECODE and held until reset.
  always_comb begin
    stage_next = stage;
    case (stage)
      FETCH:     stage_next = DECODE;
      DECODE:    stage_next = (op == OP_HALT) ? HALT : EXECUTE;
      EXECUTE:   stage_next = MEMORY;
      MEMORY:    stage_next = WRITEBACK;
      WRITEBACK: stage_next = FETCH;
      HALT:      stage_next = HALT;
      default:   stage_next = FETCH;
    endcase
  end

  // ALU, operand select and writeback control.
  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:                alu_res = a + b;
      OP_SUB:                alu_res = a - b;
      OP_AND:                alu_res = a & b;
      OP_OR:                 alu_res = a | b;
      OP_XOR:                alu_res = a ^ b;
      OP_ADDI, OP_LD, OP_ST: alu_res = a + imm6_sext;
      OP_LDI:                alu_res = {7'b0, ir[8:0]};
      default:               alu_res = '0;
    endcase
    // ST and BEQ need rd as their second operand instead of rt.
    ra2   = (op == OP_ST || op == OP_BEQ) ? rd : rt;
    rf_we = (stage == WRITEBACK) && writes_rd(op);
    rf_wd = (op == OP_LD) ? mdr : alu_out;
  end

  // Datapath registers updated per stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc      <= '0;
      ir      <= '0;
      a       <= '0;
      b       <= '0;
      alu_out <= '0;
      mdr     <= '0;
      maddr   <= '0;
      mwdata  <= '0;
      mwe     <= 1'b0;
    end else begin
      case (stage)
        FETCH: begin
          ir <= rom_data;
          pc <= pc + 8'd1;
        end
        DECODE: begin
          a <= rd1;
          b <= rd2;
        end
        EXECUTE: begin
          alu_out <= alu_res;
          if (op == OP_BEQ && a == b) pc <= pc + imm6_sext[7:0];
          if (op == OP_JMP)           pc <= ir[7:0];
          // Memory address/data are registered here so they are stable
          // throughout the MEMORY cycle.
          if (op == OP_LD || op == OP_ST) maddr <= alu_res[7:0];
          if (op == OP_ST) begin
            mwdata <= b;
            mwe    <= 1'b1;
          end
        end
        MEMORY: begin
          mwe <= 1'b0;
          if (op == OP_LD) mdr <= cur_memory_data;
        end
        default: ;
      endcase
    end
  end

  RegisterFile u_RegisterFile (
    .clk (clk),
    .rst (rst),
    .ra1 (rs),
    .ra2 (ra2),
    .rd1 (rd1),
    .rd2 (rd2),
    .we  (rf_we),
    .wa  (rd),
    .wd  (rf_wd)
  );

endmodule

// File: rtl/computer_mem.sv
// Program ROM and data RAM, both 256 x 16 with combinational reads.
module ROM
  import computer_pkg::*;
(
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  logic [DATA_W-1:0] memory [0:255] = '{default: '0};

  assign data = memory[addr];

endmodule

module RAM
  import computer_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] memory [0:255] = '{default: '0};

  assign rdata = memory[addr];

  // Synchronous write port.
  always_ff @(posedge clk) begin
    if (we) memory[addr] <= wdata;
  end

endmodule

// File: rtl/computer.sv
// Top level: CPU core with program ROM and data RAM; clock and reset only.
module computer
  import computer_pkg::*;
(
  input logic clk,
  input logic rst
);

  logic [ADDR_W-1:0] pc_addr;
  logic [DATA_W-1:0] instruction;
  logic [DATA_W-1:0] rom_data;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] cur_memory_data;
  logic [DATA_W-1:0] mem_data_write;
  logic              mem_write_enabled;

  ROM u_ROM (
    .addr (pc_addr),
    .data (rom_data)
  );

  // A store whose MEMORY cycle coincides with reset is aborted.
  RAM u_RAM (
    .clk   (clk),
    .we    (mem_write_enabled & ~rst),
    .addr  (mem_addr),
    .wdata (mem_data_write),
    .rdata (cur_memory_data)
  );

  MCPU u_MCPU (
    .clk               (clk),
    .rst               (rst),
    .rom_data          (rom_data),
    .cur_memory_data   (cur_memory_data),
    .pc_addr           (pc_addr),
    .instruction       (instruction),
    .mem_addr          (mem_addr),
    .mem_data_write    (mem_data_write),
    .mem_write_enabled (mem_write_enabled)
  );

endmodule

// File: tb/tb_computer.sv
// Directed self-checking bench for the computer, plus the program tracer.
module program_tracer (
  input logic         clk,
  input logic [7:0]   PC,
  input logic [15:0]  instr,
  input logic [127:0] cpu_registers,
  input logic [7:0]   mem_addr,
  input logic [15:0]  mem_data_in,
  input logic [15:0]  mem_data_out,
  input logic         mem_write,
  input logic [2:0]   stage
);

  function automatic string stage_name(input logic [2:0] s);
    case (s)
      3'd0:    return "FETCH";
      3'd1:    return "DECODE";
      3'd2:    return "EXECUTE";
      3'd3:    return "MEMORY";
      3'd4:    return "WRITEBACK";
      3'd5:    return "HALT";
      default: return "?";
    endcase
  endfunction

  // One trace line per rising edge.
  always @(posedge clk) begin
    $display("%0t %s pc=%0d instr=%b r=%0d %0d %0d %0d %0d %0d %0d %0d mem[%0d] in=%0d out=%0d%s",
             $time, stage_name(stage), PC, instr,
             cpu_registers[15:0], cpu_registers[31:16], cpu_registers[47:32],
             cpu_registers[63:48], cpu_registers[79:64], cpu_registers[95:80],
             cpu_registers[111:96], cpu_registers[127:112],
             mem_addr, mem_data_in, mem_data_out, mem_write ? " W" : "");
  end

endmodule

module tb_computer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   we_cnt;
  logic [7:0] we_addr;

  always #5 clk = ~clk;

  computer dut (
    .clk (clk),
    .rst (rst)
  );

  program_tracer u_tracer (
    .clk           (clk),
    .PC            (dut.pc_addr),
    .instr         (dut.instruction),
    .cpu_registers (dut.u_MCPU.u_RegisterFile.cpu_registers),
    .mem_addr      (dut.mem_addr),
    .mem_data_in   (dut.cur_memory_data),
    .mem_data_out  (dut.mem_data_write),
    .mem_write     (dut.mem_write_enabled),
    .stage         (dut.u_MCPU.stage)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] reg_val(input int i);
    return dut.u_MCPU.u_RegisterFile.cpu_registers[i*16 +: 16];
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Steps n cycles while counting store-enable cycles and their address.
  task automatic run_count(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (dut.mem_write_enabled) begin
        we_cnt++;
        we_addr = dut.mem_addr;
      end
    end
  endtask

  task automatic rom_clear();
    for (int i = 0; i < 256; i++) dut.u_ROM.memory[i] = '0;
  endtask

  task automatic rom(input int a, input logic [15:0] v);
    dut.u_ROM.memory[a] = v;
  endtask

  initial begin
    // Power-up without any reset edge.
    rom_clear();
    rom(0, 16'h7205);             // LDI r1,5
    rom(1, 16'hF000);             // HALT
    #1;
    check("pwr_stage", dut.u_MCPU.stage, 0);
    check("pwr_pc", dut.pc_addr, 0);
    check("pwr_instr", dut.instruction, 0);
    check("pwr_we", dut.mem_write_enabled, 0);
    tick(10);
    check("pwr_r1", reg_val(1), 5);
    check("pwr_stage_halt", dut.u_MCPU.stage, 5);
    check("pwr_pc_halt", dut.pc_addr, 2);

    // ALU, store, load, r0 handling.
    rst = 1'b1;
    rom_clear();
    rom(0, 16'h7205);             // LDI r1,5
    rom(1, 16'h7403);             // LDI r2,3
    rom(2, 16'h1650);             // ADD r3,r1,r2
    rom(3, 16'h9600);             // ST r3,[r0+0]
    rom(4, 16'h2888);             // SUB r4,r2,r1
    rom(5, 16'h8A00);             // LD r5,[r0+0]
    rom(6, 16'h1050);             // ADD r0,r1,r2
    rom(7, 16'h6C07);             // ADDI r6,r0,7
    rom(8, 16'hF000);             // HALT
    tick(1);
    check("rst_r1_cleared", reg_val(1), 0);
    check("rst_pc", dut.pc_addr, 0);
    check("rst_stage", dut.u_MCPU.stage, 0);
    rst = 1'b0;
    we_cnt = 0;
    we_addr = 8'hFF;
    run_count(60);
    check("alu_r1", reg_val(1), 5);
    check("alu_r2", reg_val(2), 3);
    check("add_r3", reg_val(3), 8);
    check("sub_wrap_r4", reg_val(4), 16'hFFFE);
    check("ld_r5", reg_val(5), 8);
    check("r0_write_ignored", reg_val(0), 0);
    check("r0_read_zero_r6", reg_val(6), 7);
    check("st_ram0", dut.u_RAM.memory[0], 8);
    check("st_we_cycles", we_cnt, 1);
    check("st_we_addr", we_addr, 0);
    check("prog2_stage", dut.u_MCPU.stage, 5);
    check("prog2_pc", dut.pc_addr, 9);
    check("prog2_we_idle", dut.mem_write_enabled, 0);

    // Down-counting store loop writes RAM[i]=i for i=9..0.
    rst = 1'b1;
    rom_clear();
    rom(0, 16'h7209);             // LDI r1,9
    rom(1, 16'h643F);             // ADDI r2,r0,-1
    rom(2, 16'h9240);             // ST r1,[r1+0]
    rom(3, 16'h627F);             // ADDI r1,r1,-1
    rom(4, 16'hA281);             // BEQ r1,r2,+1
    rom(5, 16'hA03C);             // BEQ r0,r0,-4
    rom(6, 16'hF000);             // HALT
    tick(1);
    rst = 1'b0;
    tick(300);
    for (int i = 0; i < 10; i++)
      check($sformatf("loop_ram%0d", i), dut.u_RAM.memory[i], i);
    check("loop_r1", reg_val(1), 16'hFFFF);
    check("loop_stage", dut.u_MCPU.stage, 5);
    check("loop_pc", dut.pc_addr, 7);

    // BEQ taken with offset -2 returns to the loop head.
    rst = 1'b1;
    rom_clear();
    rom(0, 16'h7203);             // LDI r1,3
    rom(1, 16'h7403);             // LDI r2,3
    rom(2, 16'h0000);             // NOP (loop head)
    rom(3, 16'hA2BE);             // BEQ r1,r2,-2
    tick(1);
    rst = 1'b0;
    tick(16);
    check("beq_pc_after_fetch", dut.pc_addr, 4);
    tick(2);
    check("beq_pc_taken", dut.pc_addr, 2);
    tick(10);
    check("beq_pc_taken_again", dut.pc_addr, 2);

    // JMP 255 then fetch wraps PC to 0.
    rst = 1'b1;
    rom_clear();
    rom(0, 16'hB0FF);             // JMP 255
    rom(255, 16'h77AB);           // LDI r3,0x1AB
    tick(1);
    rst = 1'b0;
    tick(3);
    check("jmp_pc", dut.pc_addr, 255);
    tick(3);
    check("wrap_pc", dut.pc_addr, 0);
    check("wrap_instr", dut.instruction, 16'h77AB);
    tick(4);
    check("wrap_r3", reg_val(3), 16'h01AB);

    // Reset during MEMORY of a store aborts the write.
    rst = 1'b1;
    rom_clear();
    rom(0, 16'h7207);             // LDI r1,7
    rom(1, 16'h9214);             // ST r1,[r0+20]
    rom(2, 16'hF000);             // HALT
    tick(1);
    rst = 1'b0;
    tick(8);
    check("abort_in_memory", dut.u_MCPU.stage, 3);
    check("abort_we_pending", dut.mem_write_enabled, 1);
    check("abort_addr", dut.mem_addr, 20);
    rst = 1'b1;
    tick(1);
    check("abort_ram20", dut.u_RAM.memory[20], 0);
    check("abort_pc", dut.pc_addr, 0);
    check("abort_stage", dut.u_MCPU.stage, 0);
    check("abort_r1", reg_val(1), 0);
    check("abort_we", dut.mem_write_enabled, 0);
    check("abort_instr", dut.instruction, 0);
    check("abort_maddr", dut.mem_addr, 0);
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
